memory_responder: RTL
=====================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the number of cycles from request acceptance to response; legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning the number of address bits used for indexing; storage is 2**ADDR_BITS words of 16 bits.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port memory_request, input, 33 bits: [32] is the write flag (1 = write, 0 = read), [31:16] is write data, [15:0] is the address.
REQ-006 SHALL have port memory_request_ready, input, 1 bit: the request is valid; the cache holds it high until the response.
REQ-007 SHALL have port memory_response, output, 16 bits: read data, or the written data for a write acknowledge.
REQ-008 SHALL have port memory_response_ready, output, 1 bit: a one-cycle pulse marking memory_response valid.
REQ-009 SHALL have port busy, output, 1 bit: high while a request is accepted and not yet responded.

Function
REQ-010 SHALL implement states IDLE, WAIT and RESPOND.
REQ-011 In IDLE, SHALL accept a request at edge k when memory_request_ready=1 and the armed flag=1.
- On acceptance: latch memory_request, load the counter, enter WAIT, set busy=1.
REQ-012 SHALL clear the armed flag on acceptance, and set it at any edge where memory_request_ready=0 is sampled.
- Effect: a request held high across a response is never accepted twice.
REQ-013 For a write, SHALL commit the data to word address[ADDR_BITS-1:0] at acceptance edge k.
REQ-014 Address bits [15:ADDR_BITS] SHALL be ignored, so addresses alias modulo 2**ADDR_BITS; no error is signalled.
REQ-015 SHALL leave WAIT at edge k+LATENCY, entering RESPOND. At that same edge it SHALL:
- drive memory_response_ready=1;
- drive memory_response = the storage word (read) or the latched write data (write).
REQ-016 With LATENCY=1, SHALL go from IDLE directly to RESPOND at the edge after acceptance.
REQ-017 memory_response_ready SHALL be high for exactly one cycle; at the next edge the block SHALL:
- drop memory_response_ready to 0;
- clear busy;
- return to IDLE.
REQ-018 memory_response SHALL hold its last value after the pulse until the next response.
REQ-019 In WAIT and RESPOND, SHALL ignore memory_request and memory_request_ready, except for updating the armed flag.
- A request changed mid-operation SHALL NOT alter the pending response.
REQ-020 The write-data field SHALL be ignored for reads.
REQ-021 The counter SHALL be 4 bits wide and SHALL NOT wrap; it saturates at its terminal count.

Reset
REQ-022 While reset=1 at an edge, SHALL set:
- state IDLE, armed=1;
- memory_response=0, memory_response_ready=0, busy=0.
REQ-023 Reset SHALL initialise every storage word i to i, zero-extended to 16 bits.
REQ-024 Reset during WAIT or RESPOND SHALL abort the operation; no response pulse follows, and any write committed before reset is overwritten by REQ-023.
REQ-025 The first request SHALL be accepted no earlier than the first edge after reset deasserts.

Verification (LATENCY=4, ADDR_BITS=8)
REQ-026 Read after reset: {0,0,13} accepted at edge k -> memory_response=13 with a ready pulse at edge k+4, low at k+5, busy high k..k+4.
REQ-027 Write then read:
- {1,55,13} -> ack response 55 at k+4;
- drop request, then {0,128,13} -> response 55.
REQ-028 Held request: memory_request_ready stays high for 20 cycles -> exactly one pulse; dropping it for 1 cycle and reraising -> a second accept and a second pulse.
REQ-029 Aliasing: write {1,7,0x010D} -> read {0,0,0x000D} returns 7; read 0x00FF returns 255.
REQ-030 Reset at k+2 of a write {1,99,20} -> no pulse, all outputs 0, then a read of 20 returns 20.
REQ-031 LATENCY=1 build: read address 5 -> pulse with response 5 at edge k+1, one cycle wide.

Source files
------------

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency single-request memory responder
module memory_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [32:0] memory_request,
    input  logic        memory_request_ready,
    output logic [15:0] memory_response,
    output logic        memory_response_ready,
    output logic        busy
);

    localparam int         DEPTH  = 2 ** ADDR_BITS;
    localparam logic [3:0] LP_LAT = LATENCY[3:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_armed;
    logic [3:0]             r_cnt;
    logic                   r_is_write;
    logic [15:0]            r_wdata;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [15:0]            r_resp;
    logic                   r_resp_rdy;
    logic                   r_busy;
    logic [15:0]            r_mem [0:DEPTH-1];

    logic                   w_accept;
    logic                   w_write;
    logic [15:0]            w_wdata;
    logic [ADDR_BITS-1:0]   w_addr;
    logic                   w_unused_addr;

    assign w_write  = memory_request[32];
    assign w_wdata  = memory_request[31:16];
    assign w_addr   = memory_request[ADDR_BITS-1:0];
    // Upper address bits alias silently onto the implemented range.
    assign w_unused_addr = &{1'b0, memory_request[15:ADDR_BITS]};

    // A request is taken only once per assertion of the ready input.
    assign w_accept = (r_state == S_IDLE) && memory_request_ready && r_armed;

    assign memory_response       = r_resp;
    assign memory_response_ready = r_resp_rdy;
    assign busy                  = r_busy;

    // Storage: reset loads word i with i; writes commit on the accept edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 16'(i);
            end
        end else if (w_accept && w_write) begin
            r_mem[w_addr] <= w_wdata;
        end
    end

    // Control FSM: accept, count out the latency, emit a one-cycle response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b1;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_wdata    <= 16'd0;
            r_addr     <= '0;
            r_resp     <= 16'd0;
            r_resp_rdy <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!memory_request_ready) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_write <= w_write;
                        r_wdata    <= w_wdata;
                        r_addr     <= w_addr;
                        r_cnt      <= 4'd1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // r_cnt equals the number of edges seen since acceptance.
                    if (r_cnt == LP_LAT) begin
                        r_state    <= S_RESPOND;
                        r_resp_rdy <= 1'b1;
                        r_resp     <= r_is_write ? r_wdata : r_mem[r_addr];
                    end else if (r_cnt != 4'hF) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESPOND: begin
                    r_resp_rdy <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
